// File: rtl/eight_bit_search_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : eight_bit_search_ctrl_if
// Brief    : Start/flag/result bundle between the search controller and the
//            magnitude comparator it drives.
// Revision : 1.0
// ============================================================================
interface eight_bit_search_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             less;
   logic             equal;
   logic             greater;
   logic [WIDTH-1:0] guess;
   logic             busy;
   logic             done;
   logic             err;
   logic [WIDTH-1:0] found;
   logic [3:0]       steps;

   modport master (
      input  start, less, equal, greater,
      output guess, busy, done, err, found, steps
   );

   modport slave (
      output start, less, equal, greater,
      input  guess, busy, done, err, found, steps
   );
endinterface
`default_nettype wire

// File: rtl/eight_bit_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : eight_bit_search_ctrl
// Brief    : Binary-searches the comparator's A operand by driving guesses on
//            B and narrowing [lo, hi] from the returned flags.
// Revision : 1.0
// ============================================================================
module eight_bit_search_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   eight_bit_search_ctrl_if.master  bus
);
   localparam logic [WIDTH-1:0] C_MAX   = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] C_FIRST = {1'b0, {(WIDTH-1){1'b1}}};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SEARCH = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] guess_q, guess_d;
   logic [WIDTH-1:0] found_q, found_d;
   logic [3:0]       steps_q, steps_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] w_guess_dec;
   logic [WIDTH-1:0] w_guess_inc;
   logic             w_abort;

   // Only consumed when guess is known not to be at the matching boundary.
   assign w_guess_dec = guess_q - 1'b1;
   assign w_guess_inc = guess_q + 1'b1;

   always_comb begin
      state_d = state_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      guess_d = guess_q;
      found_d = found_q;
      steps_d = steps_q;
      err_d   = err_q;
      w_abort = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d = S_SEARCH;
               lo_d    = '0;
               hi_d    = C_MAX;
               guess_d = C_FIRST;
               err_d   = 1'b0;
               steps_d = 4'd0;
            end
         end
         S_SEARCH: begin
            steps_d = (steps_q == 4'd15) ? steps_q : steps_q + 4'd1;
            if (!$onehot({bus.less, bus.equal, bus.greater})) begin
               w_abort = 1'b1;
            end else if (bus.equal) begin
               state_d = S_DONE;
               found_d = guess_q;
            end else if (bus.less) begin
               if (guess_q == '0 || lo_q > w_guess_dec) begin
                  w_abort = 1'b1;
               end else begin
                  hi_d    = w_guess_dec;
                  guess_d = WIDTH'(({1'b0, lo_q} + {1'b0, w_guess_dec}) >> 1);
               end
            end else begin
               if (guess_q == C_MAX || w_guess_inc > hi_q) begin
                  w_abort = 1'b1;
               end else begin
                  lo_d    = w_guess_inc;
                  guess_d = WIDTH'(({1'b0, w_guess_inc} + {1'b0, hi_q}) >> 1);
               end
            end
            if (w_abort) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         lo_q    <= '0;
         hi_q    <= '0;
         guess_q <= '0;
         found_q <= '0;
         steps_q <= 4'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         guess_q <= guess_d;
         found_q <= found_d;
         steps_q <= steps_d;
         err_q   <= err_d;
      end
   end

   assign bus.guess = guess_q;
   assign bus.busy  = (state_q == S_SEARCH);
   assign bus.done  = (state_q == S_DONE);
   assign bus.err   = err_q;
   assign bus.found = found_q;
   assign bus.steps = steps_q;
endmodule
`default_nettype wire

// File: tb/tb_eight_bit_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_eight_bit_search_ctrl
// Brief    : Bench with a behavioural comparator and a reference binary search.
// Revision : 1.0
// ============================================================================
module tb_eight_bit_search_ctrl;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic kill_flags = 1'b0;
   int   target = 0;

   int vectors = 0;
   int errors = 0;
   int exp_q[$];
   int prev_found = 0;

   eight_bit_search_ctrl_if #(.WIDTH(WIDTH)) bus ();

   assign bus.start   = start;
   assign bus.less    = !kill_flags && (target <  int'(bus.guess));
   assign bus.equal   = !kill_flags && (target == int'(bus.guess));
   assign bus.greater = !kill_flags && (target >  int'(bus.guess));

   eight_bit_search_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Textbook binary search over [0, 255] recording every probed value.
   function automatic void build_model(input int tgt);
      int lo;
      int hi;
      int g;
      exp_q.delete();
      lo = 0;
      hi = (1 << WIDTH) - 1;
      for (int n = 0; n < 32; n++) begin
         g = (lo + hi) / 2;
         exp_q.push_back(g);
         if (g == tgt) break;
         if (tgt < g) hi = g - 1;
         else         lo = g + 1;
      end
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         vectors++;
         if (bus.guess !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
             bus.err !== 1'b0 || bus.found !== 8'd0 || bus.steps !== 4'd0) begin
            errors++;
            $display("FAIL reset_idle cycle %0d: guess=%0d busy=%b done=%b err=%b found=%0d steps=%0d, want all 0",
                     c, bus.guess, bus.busy, bus.done, bus.err, bus.found, bus.steps);
         end
         @(posedge clk);
         #1;
      end
      prev_found = 0;
   endtask

   // fault_k > 0 zeroes all flags during comparison fault_k; noisy toggles start mid-search.
   task automatic run_search(input int tgt, input int fault_k, input bit noisy, input string name);
      int  exp_steps;
      bit  exp_err;
      int  exp_found;
      build_model(tgt);
      exp_err   = (fault_k > 0);
      exp_steps = exp_err ? fault_k : exp_q.size();
      exp_found = exp_err ? prev_found : tgt;
      target = tgt;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      vectors++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || int'(bus.guess) !== exp_q[0] || bus.steps !== 4'd0) begin
         errors++;
         $display("FAIL %s launch: busy=%b done=%b guess=%0d steps=%0d, want busy=1 done=0 guess=%0d steps=0",
                  name, bus.busy, bus.done, bus.guess, bus.steps, exp_q[0]);
      end
      for (int k = 1; k <= exp_steps; k++) begin
         kill_flags = (k == fault_k);
         if (noisy) start = 1'($urandom);
         @(posedge clk);
         #1;
         kill_flags = 1'b0;
         start = 1'b0;
         vectors++;
         if (k < exp_steps) begin
            if (bus.busy !== 1'b1 || bus.done !== 1'b0 || int'(bus.guess) !== exp_q[k] ||
                int'(bus.steps) !== k) begin
               errors++;
               $display("FAIL %s step %0d: busy=%b done=%b guess=%0d steps=%0d, want busy=1 done=0 guess=%0d steps=%0d",
                        name, k, bus.busy, bus.done, bus.guess, bus.steps, exp_q[k], k);
            end
         end else begin
            if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.err !== exp_err ||
                int'(bus.steps) !== k || int'(bus.found) !== exp_found) begin
               errors++;
               $display("FAIL %s result: busy=%b done=%b err=%b steps=%0d found=%0d, want busy=0 done=1 err=%b steps=%0d found=%0d",
                        name, bus.busy, bus.done, bus.err, bus.steps, bus.found, exp_err, k, exp_found);
            end
         end
      end
      if (!exp_err) prev_found = tgt;
   endtask

   task automatic test_hold();
      int g0;
      g0 = int'(bus.guess);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (bus.done !== 1'b1 || bus.busy !== 1'b0 || int'(bus.found) !== prev_found ||
             int'(bus.guess) !== g0) begin
            errors++;
            $display("FAIL done_hold cycle %0d: done=%b busy=%b found=%0d guess=%0d, want done=1 busy=0 found=%0d guess=%0d",
                     c, bus.done, bus.busy, bus.found, bus.guess, prev_found, g0);
         end
      end
   endtask

   task automatic test_reset_mid_search();
      target = 100;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (bus.guess !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
          bus.err !== 1'b0 || bus.found !== 8'd0 || bus.steps !== 4'd0) begin
         errors++;
         $display("FAIL reset_mid: guess=%0d busy=%b done=%b err=%b found=%0d steps=%0d, want all 0",
                  bus.guess, bus.busy, bus.done, bus.err, bus.found, bus.steps);
      end
      reset = 1'b0;
      prev_found = 0;
   endtask

   initial begin
      int t;
      test_reset();
      run_search(127, 0, 1'b0, "target_127");
      run_search(100, 0, 1'b0, "target_100");
      test_hold();
      run_search(255, 0, 1'b0, "target_255");
      run_search(0,   0, 1'b0, "target_0");
      for (int i = 0; i < 8; i++) begin
         t = int'($urandom_range(1, 255));
         run_search(t, 0, 1'b1, "random_noisy");
      end
      run_search(100, 3, 1'b0, "silent_flags");
      test_reset_mid_search();
      t = int'($urandom_range(0, 255));
      run_search(t, 0, 1'b0, "after_reset");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/eight_bit_search_ctrl.md
# eight_bit_search_ctrl

Sequential operand driver for the eight-bit magnitude comparator. It binary-searches for the comparator's A operand (the target) by driving successive guesses onto the comparator's B input and consuming the less/equal/greater flags it returns. It is a controller around the comparator, not a data consumer of it. It reports the found value, the number of comparisons used, and a protocol error if the flags are inconsistent.

## Interface
- WIDTH, 8, operand width; search range 0 .. 2^WIDTH-1
- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  synchronous, active-high
- start  input  1  begin a search; sampled only in IDLE or DONE
- less  input  1  comparator flag: target A < guess
- equal  input  1  comparator flag: target A == guess
- greater  input  1  comparator flag: target A > guess
- guess  output  WIDTH  registered; drives comparator B
- busy  output  1  high while in SEARCH
- done  output  1  high in DONE, held until next start or reset
- err  output  1  high in DONE if the search aborted
- found  output  WIDTH  located target, valid when done=1 and err=0
- steps  output  4  comparisons evaluated in the last or current search

## Operation
- Single clock; reset is synchronous and active-high.
- Reset values: guess=0, busy=0, done=0, err=0, found=0, steps=0, lo=0, hi=0, state=IDLE.
- Internal registers: lo, hi (WIDTH bits). Midpoint = (lo+hi)>>1, computed in WIDTH+1 bits with no overflow.
- Comparator is combinational. Flags are sampled in the same cycle guess is presented.
- States and transitions:
  - IDLE:
    - start=1 -> SEARCH with lo=0, hi=2^WIDTH-1, guess=2^(WIDTH-1)-1 (127), busy=1, done=0, err=0, steps=0.
  - SEARCH: each cycle, steps += 1, then:
    - Exactly one flag high, equal -> DONE with found=guess, err=0.
    - less, guess != 0 -> hi=guess-1, guess=(lo+guess-1)>>1.
    - greater, guess != max -> lo=guess+1, guess=(guess+1+hi)>>1.
    - Error -> DONE with err=1 and found unchanged. Error cases:
      - zero flags high, or more than one flag high;
      - less at guess=0;
      - greater at guess=max;
      - updated lo > hi.
  - DONE:
    - busy=0, done=1, outputs held.
    - start=1 -> restart exactly as from IDLE.
- start in SEARCH is ignored.
- reset in any state, including mid-search, returns to IDLE with all reset values on the next edge.
- steps saturates at 15. This cannot be reached with WIDTH=8 and a consistent comparator.

## Timing
- Edge E0 samples start. After E0: busy=1, guess=127.
- Comparison k is evaluated at edge Ek.
- If the target is found at comparison k: done=1 and busy=0 after Ek, so done rises k cycles after the start edge.
- For WIDTH=8, k ranges 1..9. Worst case is target=255; target=0 takes 8.
- guess changes only on clock edges, so B is stable for the full cycle.
- done and err change in the same cycle.
- The restart edge from DONE clears done. done is never high in the same cycle as busy.

## Test plan
- Bench: comparator instantiated with A=target, B=guess, flags wired back to the block.
1. reset held 2 cycles, then released with start=0 -> all outputs 0, and they stay 0 for 5 cycles.
2. target=127, start pulse -> done=1 one cycle after the start edge; found=127, steps=1, err=0.
3. target=100 -> guess sequence 127, 63, 95, 111, 103, 99, 101, 100; done after 8 cycles, found=100, steps=8.
4. target=255 -> guess sequence 127, 191, 223, 239, 247, 251, 253, 254, 255; steps=9. Then target=0 with restart from DONE -> guess sequence 127, 63, 31, 15, 7, 3, 1, 0; steps=8. No wrap occurs at either boundary.
5. Bench forces less=equal=greater=0 on the third comparison -> done=1, err=1, steps=3, found retains its previous value.
6. reset asserted at the fourth SEARCH cycle -> IDLE, all outputs 0 on the next edge. start during SEARCH -> no effect on the guess sequence.
